alu_issue_fsm: RTL and testbench
================================

Name: alu_issue_fsm

Overview:
- Multi-cycle initiator for the 32-bit ALU: it drives the ALU's in0/in1/ALUCtrl inputs and samples its ALUOut/Zero outputs.
- It accepts one decoded operation at a time from decode over a valid/ready handshake. It sequences one ALU pass for arithmetic/logic ops and two passes for branches (compare, then target add).
- It returns the result over a valid/ready handshake to writeback/PC logic.
- It sits between decode and the combinational ALU in the multi-cycle datapath.

Parameters:
- DW, 32, operand/result width; must match the ALU width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- ReqValid  input  1  decode presents an operation.
- ReqReady  output  1  high only in IDLE; a transfer occurs on a clk edge with ReqValid&&ReqReady.
- ReqOp  input  3  0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 NOR, 6 BEQ, 7 BNE.
- ReqA  input  DW  operand A.
- ReqB  input  DW  operand B.
- ReqPC  input  DW  PC of the instruction (branches only).
- ReqImm  input  DW  sign-extended branch offset (branches only).
- AluIn0  output  DW  to ALU in0.
- AluIn1  output  DW  to ALU in1.
- AluCtrl  output  4  to ALU ALUCtrl.
- AluOut  input  DW  from ALU ALUOut.
- AluZero  input  1  from ALU Zero.
- RespValid  output  1  result available.
- RespReady  input  1  consumer accepts the result.
- RespData  output  DW  ALU result (0 for branches).
- RespIsBr  output  1  response is a branch.
- RespTaken  output  1  branch taken.
- RespTarget  output  DW  ReqPC+ReqImm (branches only, else 0).

Behaviour:
- **ALU code mapping:** AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100. BEQ and BNE use SUB for the compare pass and ADD for the target pass. The ALU's SLT is an unsigned compare; this block passes it through unchanged.
- **States:** IDLE, EXEC, BTGT, RESP. The encoding is local to the block.
- **IDLE:**
  - ReqReady=1.
  - On handshake: register Op/A/B/PC/Imm, go to EXEC.
  - ALU outputs are 0/0/0000.
- **EXEC:**
  - AluIn0=A, AluIn1=B, AluCtrl=code(Op), all from registers only (no combinational path from Req* to Alu*).
  - At the clk edge, non-branch: RespData<=AluOut, RespIsBr<=0, RespTaken<=0, RespTarget<=0, go to RESP.
  - At the clk edge, branch: Taken<=AluZero (BEQ) or ~AluZero (BNE), go to BTGT.
- **BTGT:**
  - AluIn0=PC, AluIn1=Imm, AluCtrl=0010.
  - At the edge: RespTarget<=AluOut, RespData<=0, RespIsBr<=1, go to RESP.
- **RESP:**
  - RespValid=1; all Resp* outputs held stable until RespReady.
  - On RespValid&&RespReady: go to IDLE.
  - ALU outputs return to 0/0/0000.
- **Latency (handshake at edge N):**
  - Non-branch: RespValid rises after edge N+1.
  - Branch: RespValid rises after edge N+2.
  - Earliest next accept: the edge after the response handshake (ReqReady=0 while RespValid=1, no overlap).
- **Throughput:** one operation in flight at most. Best case is 3 cycles/op for ALU ops and 4 for branches.
- **Arithmetic:** all DW-bit and wrapping. The target add wraps modulo 2^DW (PC=0xFFFFFFFC, Imm=8 -> 0x00000004). No overflow flag.
- **Reset:**
  - Values: state=IDLE, ReqReady=1 in the cycle after reset deasserts, RespValid=0, all Resp* =0, AluIn0/AluIn1=0, AluCtrl=0000, internal registers=0.
  - Reset asserted in any state, including RESP with RespValid high, aborts immediately. The pending response is discarded with no handshake.
- **Input stability:** ReqValid high while ReqReady=0 is ignored; Req* may change freely then.
- **Response stall:** RespReady low for any number of cycles holds RESP indefinitely.
- **Same-edge events:** RespReady high in the same cycle RespValid first rises completes the transfer at that edge.

Optional Feature:
- Macro: ALU_ISSUE_PERF_EN.
- When defined, adds outputs PerfOps[31:0] (count of completed response handshakes) and PerfTaken[31:0] (count of completed responses with RespIsBr&&RespTaken).
  - Both are cleared by rst and wrap at 2^32.
  - Both increment on the response handshake edge.
- When undefined, these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- **ADD, immediate accept:** after reset, ReqOp=2, A=5, B=7 with RespReady=1 -> AluCtrl=0010 during EXEC; RespValid one cycle later, RespData=12, RespIsBr=0; ReqReady high the following cycle.
- **Every ALU op:** SUB, AND, OR, NOR, SLT with A=0x0000000F, B=0x000000F0 -> RespData 0xFFFFFF1F, 0x00000000, 0x000000FF, 0xFFFFFF00, 0x00000001; SLT with A=0xFFFFFFFF, B=1 -> 0.
- **BEQ taken with wrap:** A=B=0x1234, PC=0xFFFFFFFC, Imm=8 -> EXEC AluCtrl=0110, BTGT AluCtrl=0010; RespTaken=1, RespTarget=0x00000004, RespIsBr=1, RespData=0; BNE with the same operands -> RespTaken=0.
- **Backpressure:** RespReady=0 for 5 cycles after RespValid rises -> outputs stable, ReqReady=0 and ReqValid ignored; after RespReady=1 and the handshake, the next request is accepted one cycle later.
- **Reset mid-op:** assert rst in BTGT, and separately in RESP -> next cycle RespValid=0, all outputs 0, ReqReady=1; the following request completes normally.
- **Perf (ALU_ISSUE_PERF_EN):** 3 ADDs, 2 taken BEQs, 1 not-taken BNE -> PerfOps=6, PerfTaken=2; rst clears both.

Source files
------------

// File: rtl/alu_issue_fsm.sv
// Multi-cycle issue sequencer for the 32-bit combinational ALU.
// Optional perf counters: define ALU_ISSUE_PERF_EN.
module alu_issue_fsm #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ReqValid,
    output logic          ReqReady,
    input  logic [2:0]    ReqOp,
    input  logic [DW-1:0] ReqA,
    input  logic [DW-1:0] ReqB,
    input  logic [DW-1:0] ReqPC,
    input  logic [DW-1:0] ReqImm,
    output logic [DW-1:0] AluIn0,
    output logic [DW-1:0] AluIn1,
    output logic [3:0]    AluCtrl,
    input  logic [DW-1:0] AluOut,
    input  logic          AluZero,
    output logic          RespValid,
    input  logic          RespReady,
    output logic [DW-1:0] RespData,
    output logic          RespIsBr,
    output logic          RespTaken,
    output logic [DW-1:0] RespTarget
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]   PerfOps,
    output logic [31:0]   PerfTaken
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        BTGT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;
    localparam logic [2:0] OP_NOR = 3'd5;
    localparam logic [2:0] OP_BEQ = 3'd6;
    localparam logic [2:0] OP_BNE = 3'd7;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_NOR = 4'b1100;

    state_t state_q;
    state_t state_d;

    logic [2:0]    op_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [DW-1:0] pc_q;
    logic [DW-1:0] imm_q;

    logic is_br;
    logic st_exec;
    logic st_btgt;
    logic hs_req;
    logic hs_resp;

    // Branches compare with SUB, so both BEQ and BNE share that code.
    function automatic logic [3:0] alu_code(input logic [2:0] op);
        logic [3:0] c;
        c = C_AND;
        unique case (op)
            OP_AND: c = C_AND;
            OP_OR:  c = C_OR;
            OP_ADD: c = C_ADD;
            OP_SUB: c = C_SUB;
            OP_SLT: c = C_SLT;
            OP_NOR: c = C_NOR;
            OP_BEQ,
            OP_BNE: c = C_SUB;
            default: c = C_AND;
        endcase
        return c;
    endfunction

    assign is_br   = (op_q == OP_BEQ) || (op_q == OP_BNE);
    assign st_exec = (state_q == EXEC);
    assign st_btgt = (state_q == BTGT);
    assign hs_req  = (state_q == IDLE) && ReqValid;
    assign hs_resp = (state_q == RESP) && RespReady;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one ALU pass for ops, two for branches.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (ReqValid) state_d = EXEC;
            EXEC: state_d = is_br ? BTGT : RESP;
            BTGT: state_d = RESP;
            RESP: if (RespReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: ALU is driven only from latched request fields.
    always_comb begin
        ReqReady  = (state_q == IDLE);
        RespValid = (state_q == RESP);
        AluIn0    = '0;
        AluIn1    = '0;
        AluCtrl   = C_AND;
        unique case (1'b1)
            st_exec: begin
                AluIn0  = a_q;
                AluIn1  = b_q;
                AluCtrl = alu_code(op_q);
            end
            st_btgt: begin
                AluIn0  = pc_q;
                AluIn1  = imm_q;
                AluCtrl = C_ADD;
            end
            default: begin
                AluIn0  = '0;
                AluIn1  = '0;
                AluCtrl = C_AND;
            end
        endcase
    end

    // Request capture and response assembly from ALU results.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            RespData   <= '0;
            RespIsBr   <= 1'b0;
            RespTaken  <= 1'b0;
            RespTarget <= '0;
        end else begin
            if (hs_req) begin
                op_q  <= ReqOp;
                a_q   <= ReqA;
                b_q   <= ReqB;
                pc_q  <= ReqPC;
                imm_q <= ReqImm;
            end
            if (st_exec) begin
                if (is_br) begin
                    RespTaken <= (op_q == OP_BEQ) ? AluZero : ~AluZero;
                end else begin
                    RespData   <= AluOut;
                    RespIsBr   <= 1'b0;
                    RespTaken  <= 1'b0;
                    RespTarget <= '0;
                end
            end
            if (st_btgt) begin
                RespTarget <= AluOut;
                RespData   <= '0;
                RespIsBr   <= 1'b1;
            end
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    // Count completed responses and taken branches at handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            PerfOps   <= '0;
            PerfTaken <= '0;
        end else if (hs_resp) begin
            PerfOps <= PerfOps + 32'd1;
            if (RespIsBr && RespTaken) begin
                PerfTaken <= PerfTaken + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_fsm.sv
// Bench for alu_issue_fsm: ALU model, transaction-level reference,
// per-cycle compare, directed literal cases and random traffic.
module tb_alu_issue_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        ReqValid;
    logic        ReqReady;
    logic [2:0]  ReqOp;
    logic [31:0] ReqA, ReqB, ReqPC, ReqImm;
    logic [31:0] AluIn0, AluIn1, AluOut;
    logic [3:0]  AluCtrl;
    logic        AluZero;
    logic        RespValid, RespReady;
    logic [31:0] RespData, RespTarget;
    logic        RespIsBr, RespTaken;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] PerfOps, PerfTaken;
`endif

    int checks = 0;
    int errors = 0;

    alu_issue_fsm #(.DW(32)) dut (
        .clk(clk), .rst(rst),
        .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqOp(ReqOp), .ReqA(ReqA), .ReqB(ReqB),
        .ReqPC(ReqPC), .ReqImm(ReqImm),
        .AluIn0(AluIn0), .AluIn1(AluIn1), .AluCtrl(AluCtrl),
        .AluOut(AluOut), .AluZero(AluZero),
        .RespValid(RespValid), .RespReady(RespReady),
        .RespData(RespData), .RespIsBr(RespIsBr),
        .RespTaken(RespTaken), .RespTarget(RespTarget)
`ifdef ALU_ISSUE_PERF_EN
        , .PerfOps(PerfOps), .PerfTaken(PerfTaken)
`endif
    );

    always #5 clk = ~clk;

    // Combinational ALU the block drives.
    always_comb begin
        AluOut = 32'd0;
        case (AluCtrl)
            4'b0000: AluOut = AluIn0 & AluIn1;
            4'b0001: AluOut = AluIn0 | AluIn1;
            4'b0010: AluOut = AluIn0 + AluIn1;
            4'b0110: AluOut = AluIn0 - AluIn1;
            4'b0111: AluOut = (AluIn0 < AluIn1) ? 32'd1 : 32'd0;
            4'b1100: AluOut = ~(AluIn0 | AluIn1);
            default: AluOut = 32'd0;
        endcase
        AluZero = (AluOut == 32'd0);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] op_result(input logic [2:0] op,
            input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd3: return a - b;
            3'd4: return (a < b) ? 32'd1 : 32'd0;
            3'd5: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] code_of(input logic [2:0] op);
        case (op)
            3'd0: return 4'b0000;
            3'd1: return 4'b0001;
            3'd2: return 4'b0010;
            3'd4: return 4'b0111;
            3'd5: return 4'b1100;
            default: return 4'b0110;
        endcase
    endfunction

    // Reference: one transaction in flight, cycles-to-valid counter.
    logic        m_init = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_valid = 1'b0;
    int          m_wait = 0;
    logic [2:0]  m_op;
    logic [31:0] m_a, m_b, m_pc, m_imm;
    logic [31:0] e_data, e_target;
    logic        e_isbr, e_taken;
    logic [31:0] m_ops, m_tk;

    always @(posedge clk) begin
        if (rst) begin
            m_init  <= 1'b1;
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_wait  <= 0;
            m_ops   <= 32'd0;
            m_tk    <= 32'd0;
        end else if (!m_busy) begin
            if (ReqValid) begin
                m_busy   <= 1'b1;
                m_op     <= ReqOp;
                m_a      <= ReqA;
                m_b      <= ReqB;
                m_pc     <= ReqPC;
                m_imm    <= ReqImm;
                m_wait   <= (ReqOp >= 3'd6) ? 2 : 1;
                e_isbr   <= (ReqOp >= 3'd6);
                e_taken  <= (ReqOp == 3'd6) ? (ReqA == ReqB) :
                            (ReqOp == 3'd7) ? (ReqA != ReqB) : 1'b0;
                e_target <= (ReqOp >= 3'd6) ? ReqPC + ReqImm : 32'd0;
                e_data   <= op_result(ReqOp, ReqA, ReqB);
            end
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) m_valid <= 1'b1;
        end else if (RespReady) begin
            m_valid <= 1'b0;
            m_busy  <= 1'b0;
            m_ops   <= m_ops + 32'd1;
            if (e_isbr && e_taken) m_tk <= m_tk + 32'd1;
        end
    end

    // Per-cycle compare against the reference.
    always @(negedge clk) begin
        if (m_init) begin
            logic [31:0] x0, x1;
            logic [3:0]  xc;
            x0 = 32'd0;
            x1 = 32'd0;
            xc = 4'd0;
            if (m_busy && !m_valid && m_wait == (e_isbr ? 2 : 1)) begin
                x0 = m_a;
                x1 = m_b;
                xc = code_of(m_op);
            end else if (m_busy && !m_valid && e_isbr && m_wait == 1) begin
                x0 = m_pc;
                x1 = m_imm;
                xc = 4'b0010;
            end
            chk("ReqReady", ReqReady, !m_busy);
            chk("RespValid", RespValid, m_valid);
            chk("AluIn0", AluIn0, x0);
            chk("AluIn1", AluIn1, x1);
            chk("AluCtrl", AluCtrl, xc);
            if (m_valid) begin
                chk("RespData", RespData, e_data);
                chk("RespIsBr", RespIsBr, e_isbr);
                chk("RespTaken", RespTaken, e_taken);
                chk("RespTarget", RespTarget, e_target);
            end
`ifdef ALU_ISSUE_PERF_EN
            chk("PerfOps", PerfOps, m_ops);
            chk("PerfTaken", PerfTaken, m_tk);
`endif
        end
    end

    logic [31:0] r_data, r_target;
    logic        r_isbr, r_taken;
    logic [3:0]  r_c0, r_c1;
    int          r_lat;

    // Called just after a negedge; returns just after a negedge.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
            input logic [31:0] b, input logic [31:0] pc,
            input logic [31:0] imm, input int stall);
        int n;
        ReqValid  = 1'b1;
        ReqOp     = op;
        ReqA      = a;
        ReqB      = b;
        ReqPC     = pc;
        ReqImm    = imm;
        RespReady = (stall == 0);
        @(negedge clk);
        ReqValid = 1'b0;
        n = 0;
        r_c0 = 4'hf;
        r_c1 = 4'hf;
        while (!RespValid && n < 8) begin
            if (n == 0) r_c0 = AluCtrl;
            if (n == 1) r_c1 = AluCtrl;
            n++;
            @(negedge clk);
        end
        r_lat = n;
        chk("resp_timeout", RespValid, 1);
        r_data   = RespData;
        r_target = RespTarget;
        r_isbr   = RespIsBr;
        r_taken  = RespTaken;
        for (int i = 0; i < stall; i++) begin
            ReqValid = 1'b1;
            ReqOp    = 3'($urandom);
            ReqA     = $urandom;
            @(negedge clk);
            chk("stall_valid", RespValid, 1);
            chk("stall_ready", ReqReady, 0);
            chk("stall_data", RespData, r_data);
        end
        ReqValid  = 1'b0;
        RespReady = 1'b1;
        @(negedge clk);
        chk("ready_after", ReqReady, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, RespValid, 0);
        chk({tag, "_ready"}, ReqReady, 1);
        chk({tag, "_data"}, RespData, 0);
        chk({tag, "_target"}, RespTarget, 0);
        chk({tag, "_isbr"}, RespIsBr, 0);
        chk({tag, "_taken"}, RespTaken, 0);
        chk({tag, "_in0"}, AluIn0, 0);
        chk({tag, "_in1"}, AluIn1, 0);
        chk({tag, "_ctrl"}, AluCtrl, 0);
    endtask

    logic [2:0]  t_op  [5];
    logic [31:0] t_exp [5];

    initial begin
        rst = 1'b1;
        ReqValid = 1'b0;
        ReqOp = 3'd0;
        ReqA = 32'd0;
        ReqB = 32'd0;
        ReqPC = 32'd0;
        ReqImm = 32'd0;
        RespReady = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("reset");

        run_op(3'd2, 32'd5, 32'd7, 32'd0, 32'd0, 0);
        chk("add_data", r_data, 32'd12);
        chk("add_ctrl", r_c0, 4'b0010);
        chk("add_lat", r_lat, 1);
        chk("add_isbr", r_isbr, 0);

        t_op  = '{3'd3, 3'd0, 3'd1, 3'd5, 3'd4};
        t_exp = '{32'hFFFFFF1F, 32'h0, 32'hFF, 32'hFFFFFF00, 32'h1};
        for (int i = 0; i < 5; i++) begin
            run_op(t_op[i], 32'h0000000F, 32'h000000F0, 32'd0, 32'd0, 0);
            chk($sformatf("op%0d_data", t_op[i]), r_data, t_exp[i]);
        end
        run_op(3'd4, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 0);
        chk("slt_unsigned", r_data, 32'd0);

        run_op(3'd6, 32'h1234, 32'h1234, 32'hFFFFFFFC, 32'd8, 0);
        chk("beq_taken", r_taken, 1);
        chk("beq_target", r_target, 32'h4);
        chk("beq_isbr", r_isbr, 1);
        chk("beq_data", r_data, 32'd0);
        chk("beq_c0", r_c0, 4'b0110);
        chk("beq_c1", r_c1, 4'b0010);
        chk("beq_lat", r_lat, 2);
        run_op(3'd7, 32'h1234, 32'h1234, 32'hFFFFFFFC, 32'd8, 0);
        chk("bne_taken", r_taken, 0);
        chk("bne_target", r_target, 32'h4);

        run_op(3'd2, 32'd100, 32'd23, 32'd0, 32'd0, 5);
        chk("bp_data", r_data, 32'd123);
        run_op(3'd1, 32'h30, 32'h0C, 32'd0, 32'd0, 0);
        chk("bp_next_data", r_data, 32'h3C);
        chk("bp_next_lat", r_lat, 1);

        ReqValid = 1'b1;
        ReqOp = 3'd6;
        ReqA = 32'd9;
        ReqB = 32'd9;
        ReqPC = 32'h100;
        ReqImm = 32'h20;
        RespReady = 1'b1;
        @(negedge clk);
        ReqValid = 1'b0;
        @(negedge clk);
        chk("rbt_ctrl", AluCtrl, 4'b0010);
        do_reset();
        chk_idle("rst_btgt");
        run_op(3'd2, 32'd1, 32'd2, 32'd0, 32'd0, 0);
        chk("rbt_after", r_data, 32'd3);

        ReqValid = 1'b1;
        ReqOp = 3'd2;
        ReqA = 32'd3;
        ReqB = 32'd4;
        RespReady = 1'b0;
        @(negedge clk);
        ReqValid = 1'b0;
        @(negedge clk);
        chk("rresp_valid", RespValid, 1);
        do_reset();
        chk_idle("rst_resp");
        run_op(3'd3, 32'd10, 32'd4, 32'd0, 32'd0, 0);
        chk("rresp_after", r_data, 32'd6);

`ifdef ALU_ISSUE_PERF_EN
        do_reset();
        for (int i = 0; i < 3; i++)
            run_op(3'd2, 32'(i), 32'd1, 32'd0, 32'd0, 0);
        for (int i = 0; i < 2; i++)
            run_op(3'd6, 32'd7, 32'd7, 32'h40, 32'h8, 0);
        run_op(3'd7, 32'd5, 32'd5, 32'h40, 32'h8, 0);
        chk("perf_ops", PerfOps, 32'd6);
        chk("perf_taken", PerfTaken, 32'd2);
        do_reset();
        chk("perf_ops_rst", PerfOps, 32'd0);
        chk("perf_taken_rst", PerfTaken, 32'd0);
`endif

        repeat (3000) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 199) == 0);
            ReqValid  = $urandom_range(0, 1) == 1;
            ReqOp     = 3'($urandom);
            ReqA      = $urandom_range(0, 3) == 0 ?
                        32'($urandom_range(0, 7)) : $urandom;
            ReqB      = $urandom_range(0, 3) == 0 ? ReqA :
                        $urandom_range(0, 3) == 0 ?
                        32'($urandom_range(0, 7)) : $urandom;
            ReqPC     = $urandom;
            ReqImm    = $urandom;
            RespReady = $urandom_range(0, 3) != 0;
        end
        @(negedge clk);
        rst = 1'b0;
        ReqValid = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
